// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch / branch control slice.
//   ADDR_W, INSTR_W : PC/ROM address width and instruction word width
//   OP_*            : control-flow opcodes carried in instr[11:8]
//   state_t         : sequencer states
//   opcode_of()     : extracts the opcode field from an instruction word
package fetch_pkg;

  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 12;

  localparam logic [3:0] OP_CALL = 4'hA;
  localparam logic [3:0] OP_RET  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BZ   = 4'hD;
  localparam logic [3:0] OP_BNZ  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] w);
    return w[INSTR_W-1 -: 4];
  endfunction

endpackage

// File: rtl/return_stack.sv
// return_stack: DEPTH x W LIFO holding CALL return addresses.
//   clk, rst : clock, synchronous active-high reset (clears sp and contents)
//   push/din : write din on top (ignored when full)
//   pop      : discard top entry (ignored when empty)
//   dout     : current top entry (0 when empty)
//   full, empty : occupancy flags
module return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int SW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [SW-1:0] sp;
  logic [AW-1:0] wr_idx, top_idx;

  assign full    = (sp == SW'(DEPTH));
  assign empty   = (sp == '0);
  assign wr_idx  = AW'(sp);
  assign top_idx = AW'(sp - SW'(1));
  assign dout    = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= din;
      sp          <= sp + SW'(1);
    end else if (pop && !empty) begin
      sp <= sp - SW'(1);
    end
  end

endmodule

// File: rtl/fetch_branch_ctrl.sv
// fetch_branch_ctrl: fetch sequencer and PC branch control.
//   clk, rst    : clock, synchronous active-high reset
//   start       : leave IDLE and begin fetching
//   stall       : execute stage busy, hold in FETCH
//   zero_flag   : ALU zero flag for BZ/BNZ
//   pc_in       : current PC; rom_addr mirrors it combinationally
//   rom_data    : combinational ROM read data
//   pc_en, pc_branch, pc_target : one-cycle PC update command (EXEC cycle)
//   ir, ir_valid: instruction register and its new-instruction strobe
//   halted      : HALT executed (sticky until rst)
//   stack_err   : sticky, CALL on full / RET on empty return stack
module fetch_branch_ctrl #(
  parameter int ADDR_W      = fetch_pkg::ADDR_W,
  parameter int INSTR_W     = fetch_pkg::INSTR_W,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic               zero_flag,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               pc_en,
  output logic               pc_branch,
  output logic [ADDR_W-1:0]  pc_target,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic               halted,
  output logic               stack_err
);

  import fetch_pkg::*;

  state_t state, nstate;

  logic              capture;
  logic              d_en, d_br, d_push, d_pop, d_err, d_halt;
  logic [ADDR_W-1:0] d_tgt;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] st_dout;
  logic              st_full, st_empty;

  assign rom_addr = pc_in;
  assign ret_addr = pc_in + ADDR_W'(1);  // wraps 63 -> 0

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  // next state
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:   if (start) nstate = S_FETCH;
      S_FETCH:  if (!stall) nstate = S_EXEC;
      S_EXEC:   nstate = (opcode_of(ir) == OP_HALT) ? S_HALTED : S_FETCH;
      S_HALTED: nstate = S_HALTED;
      default:  nstate = S_IDLE;
    endcase
  end

  // Decode of rom_data on the capture edge; the results are registered so
  // they appear as a single-cycle command during EXEC.
  always_comb begin
    capture = (state == S_FETCH) && !stall;
    d_en    = 1'b0;
    d_br    = 1'b0;
    d_tgt   = '0;
    d_push  = 1'b0;
    d_pop   = 1'b0;
    d_err   = 1'b0;
    d_halt  = 1'b0;
    if (capture) begin
      d_en = 1'b1;
      case (opcode_of(rom_data))
        OP_JMP: begin
          d_br  = 1'b1;
          d_tgt = rom_data[ADDR_W-1:0];
        end
        OP_BZ: if (zero_flag) begin
          d_br  = 1'b1;
          d_tgt = rom_data[ADDR_W-1:0];
        end
        OP_BNZ: if (!zero_flag) begin
          d_br  = 1'b1;
          d_tgt = rom_data[ADDR_W-1:0];
        end
        OP_CALL: begin
          if (st_full) d_err = 1'b1;  // no push, plain increment
          else begin
            d_push = 1'b1;
            d_br   = 1'b1;
            d_tgt  = rom_data[ADDR_W-1:0];
          end
        end
        OP_RET: begin
          if (st_empty) d_err = 1'b1;
          else begin
            d_pop = 1'b1;
            d_br  = 1'b1;
            d_tgt = st_dout;
          end
        end
        OP_HALT: begin
          d_en   = 1'b0;
          d_halt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_en     <= 1'b0;
      pc_branch <= 1'b0;
      pc_target <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      pc_en     <= d_en;
      pc_branch <= d_br;
      pc_target <= d_tgt;
      ir_valid  <= capture;
      if (capture) ir <= rom_data;
      if (d_halt)  halted <= 1'b1;
      if (d_err)   stack_err <= 1'b1;
    end
  end

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (d_push),
    .pop   (d_pop),
    .din   (ret_addr),
    .dout  (st_dout),
    .full  (st_full),
    .empty (st_empty)
  );

endmodule

// File: tb/tb_fetch_branch_ctrl.sv
// tb_fetch_branch_ctrl: scoreboard bench. The stimulus process walks the
// program at instruction level with its own PC and return-address list and
// queues the expected EXEC-cycle outputs; the monitor pops one entry each
// time ir_valid is seen. The PC register itself is modelled here as the
// environment: it loads on the falling edge when pc_en is high.
module tb_fetch_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        zero_flag = 1'b0;
  logic [5:0]  pc_in;
  logic [5:0]  rom_addr;
  logic [11:0] rom_data;
  logic        pc_en, pc_branch;
  logic [5:0]  pc_target;
  logic [11:0] ir;
  logic        ir_valid, halted, stack_err;

  logic [11:0] rom [64];

  fetch_branch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .zero_flag (zero_flag),
    .pc_in     (pc_in),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pc_en     (pc_en),
    .pc_branch (pc_branch),
    .pc_target (pc_target),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .halted    (halted),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  always @(negedge clk) begin
    if (rst)        pc_in <= 6'd0;
    else if (pc_en) pc_in <= pc_branch ? pc_target : pc_in + 6'd1;
  end

  typedef struct {
    logic [11:0] ir;
    logic        en;
    logic        br;
    logic [5:0]  tgt;
    logic        hlt;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   npass = 0;
  int   ntot  = 0;

  // reference model state
  int          mpc;
  int          mstk[$];
  bit          mhalt, merr;
  logic [11:0] last_ir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    ntot++;
    if (act === req) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // monitor
  always @(posedge clk) begin
    #1;
    if (ir_valid) begin
      if (sbq.size() == 0) chk("unexpected_ir_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("ir",        ir,        e.ir);
        chk("pc_en",     pc_en,     e.en);
        chk("pc_branch", pc_branch, e.br);
        chk("pc_target", pc_target, e.tgt);
        chk("halted",    halted,    e.hlt);
        chk("stack_err", stack_err, e.err);
        chk("rom_addr",  rom_addr,  pc_in);
      end
    end else begin
      chk("idle_pc_en",     pc_en,     1'b0);
      chk("idle_pc_branch", pc_branch, 1'b0);
    end
  end

  // Instruction-level model: what this instruction must do to the PC.
  task automatic predict(input bit z, output bit done);
    exp_t        e;
    logic [11:0] w;
    logic [3:0]  op;
    w = rom[mpc];
    op = w[11:8];
    e.ir = w; e.en = 1'b1; e.br = 1'b0; e.tgt = 6'd0;
    case (op)
      4'hC: begin e.br = 1'b1; e.tgt = w[5:0]; end
      4'hD: if (z)  begin e.br = 1'b1; e.tgt = w[5:0]; end
      4'hE: if (!z) begin e.br = 1'b1; e.tgt = w[5:0]; end
      4'hA: begin
        if (mstk.size() < 4) begin
          mstk.push_back((mpc + 1) % 64);
          e.br = 1'b1; e.tgt = w[5:0];
        end else merr = 1'b1;
      end
      4'hB: begin
        if (mstk.size() > 0) begin
          e.br = 1'b1; e.tgt = 6'(mstk.pop_back());
        end else merr = 1'b1;
      end
      4'hF: begin e.en = 1'b0; mhalt = 1'b1; end
      default: ;
    endcase
    e.hlt = mhalt;
    e.err = merr;
    sbq.push_back(e);
    last_ir = w;
    if (e.en) mpc = e.br ? int'(e.tgt) : (mpc + 1) % 64;
    done = mhalt;
  endtask

  task automatic model_reset();
    mpc = 0; mstk.delete(); mhalt = 1'b0; merr = 1'b0; last_ir = 12'h000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_pc_en",     pc_en,     1'b0);
    chk("rst_pc_branch", pc_branch, 1'b0);
    chk("rst_pc_target", pc_target, 6'd0);
    chk("rst_ir",        ir,        12'h000);
    chk("rst_ir_valid",  ir_valid,  1'b0);
    chk("rst_halted",    halted,    1'b0);
    chk("rst_stack_err", stack_err, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // one FETCH(+stalls)/EXEC pair; called with the DUT in FETCH
  task automatic exec_one(input int k, input bit z, output bit done);
    zero_flag = z;
    stall = 1'b1;
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      chk("ir_hold_stall", ir, last_ir);
    end
    stall = 1'b0;
    predict(z, done);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic run_prog(input int maxn, input bit rand_z);
    bit done;
    int k;
    bit z;
    done = 1'b0;
    for (int n = 0; n < maxn && !done; n++) begin
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      z = rand_z ? 1'($urandom_range(0, 1)) : (mpc == 'h16);
      exec_one(k, z, done);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 12'h000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int r;
    logic [3:0] optab [16];
    optab = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 4'hA, 4'hB, 4'hB,
              4'hC, 4'hC, 4'hD, 4'hD, 4'hE, 4'hE, 4'h1, 4'hF};
    model_reset();
    clear_rom();

    // straight-line then HALT
    rom[2] = 12'hF00;
    do_reset();
    do_start();
    run_prog(10, 1'b0);
    chk("model_halted", 32'(mhalt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("halt_hold_halted", halted, 1'b1);
      chk("halt_hold_pc_en",  pc_en,  1'b0);
      chk("halt_hold_valid",  ir_valid, 1'b0);
    end

    // JMP, BZ not-taken/taken, CALL at 0x3F (return wraps to 0), RET
    clear_rom();
    rom['h03] = 12'hC15;
    rom['h15] = 12'hD08;
    rom['h16] = 12'hD08;
    rom['h08] = 12'hC3F;
    rom['h3F] = 12'hA20;
    rom['h20] = 12'hB00;
    do_reset();
    do_start();
    run_prog(10, 1'b0);
    chk("wrap_pc", pc_in, 6'd1);

    // five nested CALLs then five RETs
    clear_rom();
    rom['h00] = 12'hC30;
    rom['h30] = 12'hA10;
    rom['h10] = 12'hA18;
    rom['h18] = 12'hA1C;
    rom['h1C] = 12'hA24;
    rom['h24] = 12'hA28;
    rom['h25] = 12'hB00;
    rom['h1D] = 12'hB00;
    rom['h19] = 12'hB00;
    rom['h11] = 12'hB00;
    rom['h31] = 12'hB00;
    rom['h32] = 12'hF00;
    do_reset();
    do_start();
    run_prog(20, 1'b0);
    chk("nest_err_sticky", stack_err, 1'b1);
    chk("nest_halted",     halted,    1'b1);

    // HALT under stall is not captured; stall 3 then reset mid-EXEC
    clear_rom();
    rom[0] = 12'hF00;
    do_reset();
    do_start();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_halt_ir",     ir,     last_ir);
      chk("stall_halt_halted", halted, 1'b0);
    end
    rom[0] = 12'h123;
    stall = 1'b0;
    predict(1'b0, done);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_pc_en",     pc_en,     1'b0);
    chk("midrst_ir",        ir,        12'h000);
    chk("midrst_ir_valid",  ir_valid,  1'b0);
    chk("midrst_stack_err", stack_err, 1'b0);
    chk("midrst_pc_target", pc_target, 6'd0);
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_fetch", ir_valid, 1'b0);
    do_start();
    exec_one(0, 1'b0, done);

    // randomized programs
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 64; i++) begin
        r = $urandom_range(0, 15);
        rom[i] = {optab[r], 2'b00, 6'($urandom_range(0, 63))};
      end
      do_reset();
      do_start();
      run_prog(40, 1'b1);
    end

    do_reset();
    @(posedge clk); #1;
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/fetch_branch_ctrl.md
# fetch_branch_ctrl

Sequencing and branch-control unit that drives the 6-bit program counter. It reads the PC value, fetches the instruction word from instruction ROM at that address and latches it into the instruction register. It then decodes control-flow opcodes and issues one PC update per instruction: increment or load a branch target. It also keeps a 4-entry return-address stack for CALL/RET and sits between the PC, the instruction ROM and the execute stage.

## Interface
Parameters:
- ADDR_W, 6, PC/ROM address width (64 locations)
- INSTR_W, 12, instruction width: opcode [11:8], target [5:0]
- STACK_DEPTH, 4, return-stack entries

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  leave IDLE and begin fetching
- stall  in  1  execute stage busy; hold in FETCH
- zero_flag  in  1  ALU zero flag for BZ/BNZ
- pc_in  in  6  current PC value (PC output)
- rom_addr  out  6  ROM address, combinationally equal to pc_in
- rom_data  in  12  ROM read data, combinational
- pc_en  out  1  PC update enable, one-cycle pulse
- pc_branch  out  1  PC loads pc_target instead of incrementing
- pc_target  out  6  branch target to PC
- ir  out  12  instruction register
- ir_valid  out  1  ir holds a new instruction this cycle
- halted  out  1  HALT executed
- stack_err  out  1  sticky: CALL on full stack or RET on empty stack

## Operation
- States: IDLE, FETCH, EXEC, HALTED.
  - IDLE -> FETCH when start=1.
  - FETCH -> EXEC when stall=0. Stall holds FETCH with no capture.
  - EXEC -> FETCH, or EXEC -> HALTED if the instruction is HALT.
  - HALTED stays until rst.
- FETCH->EXEC edge: ir <= rom_data. pc_en/pc_branch/pc_target are registered from the rom_data decode on the same edge.
- Decode rules:
  - JMP 4'hC: branch=1, target=rom_data[5:0].
  - BZ 4'hD: branch=zero_flag. BNZ 4'hE: branch=~zero_flag.
  - CALL 4'hA: push pc_in+1 (6-bit wrap, 63->0), branch to target.
  - RET 4'hB: pop, branch to popped value.
  - HALT 4'hF: pc_en=0, halted=1.
  - Others: pc_en=1, branch=0 (increment).
- Boundary conditions:
  - CALL with stack full: no push, increment only, stack_err=1.
  - RET with stack empty: increment only, stack_err=1.
  - When not branching, pc_target holds 0.
- Outside EXEC: pc_en=0, pc_branch=0, ir_valid=0, ir holds its value.

## Timing
- Reset values: state IDLE, sp 0, stack contents 0, pc_en 0, pc_branch 0, pc_target 0, ir 0, ir_valid 0, halted 0, stack_err 0.
- Throughput: 2 cycles per instruction without stall; each stall cycle adds 1.
- pc_en is high for exactly the EXEC cycle. The PC samples it on the falling edge mid-EXEC, so the next FETCH sees the updated pc_in.
- rst in any state returns to IDLE on the next edge and clears stack_err, halted and sp. pc_en is 0 in the following cycle.
- stall=1 together with a HALT on rom_data: stall wins, nothing is captured.
- start is ignored outside IDLE.

## Structure
- Shared package fetch_pkg holds:
  - opcode constants (OP_CALL, OP_RET, OP_JMP, OP_BZ, OP_BNZ, OP_HALT)
  - the state enum
  - ADDR_W and INSTR_W.
- Sub-module return_stack: STACK_DEPTH x ADDR_W LIFO.
  - Inputs: push, pop, din. Outputs: dout (top), full, empty.
  - Synchronous reset. Push when full and pop when empty are ignored.

## Test plan
- Reset, then start with ROM words 0x000, 0x000, 0xF00 at addresses 0-2 -> pc_en pulses with branch=0 at PC 0 and 1; halted=1 after the PC=2 EXEC; pc_en stays 0 thereafter.
- JMP 0xC15 at PC 3 -> pc_branch=1, pc_target=0x15; next rom_addr=0x15.
- BZ 0xD08 with zero_flag=0, then again with zero_flag=1 -> first cycle increments; second has pc_branch=1, target 0x08.
- CALL 0xA20 at PC 0x3F, then RET at 0x20 -> push of 0x00 (wrap); RET gives pc_target=0x00, stack_err stays 0.
- Five nested CALLs, then five RETs -> fifth CALL and fifth RET only increment; stack_err=1 and remains set until rst.
- stall held 3 cycles in FETCH, then rst asserted mid-EXEC -> ir unchanged during stall; after reset all outputs are 0 and state is IDLE.
